// File: rtl/exception_source.sv
// exception_source: in-order exception report queue toward GC; EXCEPTION_SOURCE_TVAL_EN adds trap-value storage
module exception_source #(
  parameter int DEPTH = 2,
  parameter int UNIT_INDEX = 0,
  parameter int ID_WIDTH = 3,
  parameter int CODE_WIDTH = 5,
  parameter int NUM_EXCEPTION_SOURCES = 4,
  localparam int PW = $clog2(DEPTH) + 1,
  localparam int UW = NUM_EXCEPTION_SOURCES > 1 ? $clog2(NUM_EXCEPTION_SOURCES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  report_valid,
  output logic                  report_ready,
  input  logic [ID_WIDTH-1:0]   report_id,
  input  logic [CODE_WIDTH-1:0] report_code,
  input  logic [31:0]           report_tval,
  input  logic                  discard_active,
  input  logic                  clear,
  output logic                  exc_valid,
  output logic [ID_WIDTH-1:0]   exc_id,
  output logic [CODE_WIDTH-1:0] exc_code,
  output logic [31:0]           exc_tval,
  input  logic                  exc_ack,
  output logic                  table_we,
  output logic [ID_WIDTH-1:0]   table_id,
  output logic [UW-1:0]         table_unit,
  output logic [PW-1:0]         pending_count
);
  typedef enum logic [1:0] {IDLE, PENDING, DISCARD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW-2:0] wr_idx, rd_idx;
  logic fresh_q, fresh_d;
  logic table_we_q, table_we_d;
  logic [ID_WIDTH-1:0] table_id_q, table_id_d;
  logic [ID_WIDTH-1:0] id_q [DEPTH];
  logic [ID_WIDTH-1:0] id_d [DEPTH];
  logic [CODE_WIDTH-1:0] code_q [DEPTH];
  logic [CODE_WIDTH-1:0] code_d [DEPTH];
  logic full, empty, ack, push;
  // queue control, handshake and state sequencing; an ack flushes the queue and drops any same-cycle report
  always_comb begin
    wr_idx = wr_q[PW-2:0];
    rd_idx = rd_q[PW-2:0];
    empty = wr_q == rd_q;
    full = (wr_q[PW-1] != rd_q[PW-1]) && (wr_idx == rd_idx);
    ack = state_q == PENDING && exc_ack;
    report_ready = state_q == DISCARD || !full || ack;
    push = report_valid && report_ready && !clear && state_q != DISCARD && !ack;
    wr_d = (clear || ack) ? '0 : push ? wr_q + 1'b1 : wr_q;
    rd_d = (clear || ack) ? '0 : rd_q;
    fresh_d = ack && !clear;
    state_d = clear ? IDLE
            : ack ? DISCARD
            : (state_q == IDLE && push) ? PENDING
            : (state_q == DISCARD && !fresh_q && !discard_active) ? IDLE
            : state_q;
    table_we_d = push;
    table_id_d = report_id;
  end
  // entry storage written at the tail
  always_comb begin
    id_d = id_q;
    code_d = code_q;
    if (push) id_d[wr_idx] = report_id;
    if (push) code_d[wr_idx] = report_code;
  end
  // presentation of the head entry; zero while empty
  always_comb begin
    exc_valid = state_q == PENDING;
    exc_id = empty ? '0 : id_q[rd_idx];
    exc_code = empty ? '0 : code_q[rd_idx];
    table_we = table_we_q;
    table_id = table_id_q;
    table_unit = UW'(UNIT_INDEX);
    pending_count = wr_q - rd_q;
  end
  // state, pointer, table-write and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      fresh_q <= 1'b0;
      table_we_q <= 1'b0;
      table_id_q <= '0;
      id_q <= '{default: '0};
      code_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      fresh_q <= fresh_d;
      table_we_q <= table_we_d;
      table_id_q <= table_id_d;
      id_q <= id_d;
      code_q <= code_d;
    end
  end
`ifdef EXCEPTION_SOURCE_TVAL_EN
  logic [31:0] tval_q [DEPTH];
  logic [31:0] tval_d [DEPTH];
  // trap-value storage alongside each entry
  always_comb begin
    tval_d = tval_q;
    if (push) tval_d[wr_idx] = report_tval;
    exc_tval = empty ? '0 : tval_q[rd_idx];
  end
  // trap-value registers
  always_ff @(posedge clk) begin
    if (rst) tval_q <= '{default: '0};
    else tval_q <= tval_d;
  end
`else
  logic unused_tval;
  assign unused_tval = ^report_tval;
  assign exc_tval = '0;
`endif
endmodule

// File: tb/tb_exception_source.sv
// tb_exception_source: queue-model checked bench for exception_source
module tb_exception_source;
  localparam int DEPTH = 2;
`ifdef EXCEPTION_SOURCE_TVAL_EN
  localparam bit TV = 1'b1;
`else
  localparam bit TV = 1'b0;
`endif
  logic clk = 0, rst = 1, report_valid = 0, discard_active = 0, clear = 0, exc_ack = 0;
  logic [2:0] report_id = 0;
  logic [4:0] report_code = 0;
  logic [31:0] report_tval = 0;
  logic report_ready, exc_valid, table_we;
  logic [2:0] exc_id, table_id;
  logic [4:0] exc_code;
  logic [31:0] exc_tval;
  logic [1:0] table_unit;
  logic [1:0] pending_count;

  always #5 clk = ~clk;

  exception_source #(.DEPTH(DEPTH), .UNIT_INDEX(2)) dut (
    .clk(clk), .rst(rst), .report_valid(report_valid), .report_ready(report_ready),
    .report_id(report_id), .report_code(report_code), .report_tval(report_tval),
    .discard_active(discard_active), .clear(clear), .exc_valid(exc_valid), .exc_id(exc_id),
    .exc_code(exc_code), .exc_tval(exc_tval), .exc_ack(exc_ack), .table_we(table_we),
    .table_id(table_id), .table_unit(table_unit), .pending_count(pending_count)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [2:0] id; logic [4:0] code; logic [31:0] tval;} rep_t;
  rep_t mq[$];
  bit m_disc = 0, m_tw = 0, started = 0, mv, ma, macc;
  int m_age = 0;
  logic [2:0] m_tid = 0;

  // reference model: a report list that GC drains wholesale on ack, then a discard window
  initial forever begin
    @(posedge clk);
    if (rst || clear) begin
      mq.delete();
      m_disc = 0;
      m_tw = 0;
    end else begin
      mv = !m_disc && mq.size() > 0;
      ma = mv && exc_ack;
      macc = report_valid && !m_disc && !ma && mq.size() < DEPTH;
      m_tw = macc;
      m_tid = report_id;
      if (ma) begin
        mq.delete();
        m_disc = 1;
        m_age = 0;
      end else if (m_disc) begin
        if (m_age > 0 && !discard_active) m_disc = 0;
        m_age++;
      end
      if (macc) mq.push_back(rep_t'{report_id, report_code, TV ? report_tval : 32'h0});
    end
    started = 1;
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      mv = !m_disc && mq.size() > 0;
      chk("exc_valid", exc_valid, mv);
      chk("exc_id", exc_id, mq.size() > 0 ? mq[0].id : 3'd0);
      chk("exc_code", exc_code, mq.size() > 0 ? mq[0].code : 5'd0);
      chk("exc_tval", exc_tval, mq.size() > 0 ? mq[0].tval : 32'h0);
      chk("pending_count", pending_count, mq.size());
      chk("report_ready", report_ready, m_disc || mq.size() < DEPTH || (mv && exc_ack));
      chk("table_we", table_we, m_tw);
      if (m_tw) chk("table_id", table_id, m_tid);
      chk("table_unit", table_unit, 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input logic v, input logic [2:0] id, input logic [4:0] code, input logic [31:0] tv);
    report_valid = v;
    report_id = id;
    report_code = code;
    report_tval = tv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    rst = 0;
    rep(1, 3, 4, 32'hDEADBEEF);
    @(negedge clk);
    chk("reset ready", report_ready, 1);
    chk("reset valid", exc_valid, 0);
    chk("reset count", pending_count, 0);
    chk("reset id", exc_id, 0);
    tick();
    rep(0, 0, 0, 0);
    @(negedge clk);
    chk("t1 table_we", table_we, 1);
    chk("t1 table_id", table_id, 3);
    chk("t1 valid", exc_valid, 1);
    chk("t1 id", exc_id, 3);
    chk("t1 code", exc_code, 4);
    chk("t1 tval", exc_tval, TV ? 32'hDEADBEEF : 32'h0);
    tick();
    @(negedge clk);
    chk("t1 table_we pulse", table_we, 0);
    exc_ack = 1;
    tick();
    exc_ack = 0;
    tick();
    tick();
    rep(1, 1, 1, 32'h11);
    tick();
    rep(1, 2, 2, 32'h22);
    tick();
    rep(1, 7, 7, 32'h77);
    @(negedge clk);
    chk("t2 count", pending_count, 2);
    chk("t2 ready", report_ready, 0);
    chk("t2 head", exc_id, 1);
    tick();
    tick();
    @(negedge clk);
    chk("t2 held count", pending_count, 2);
    chk("t2 held no write", table_we, 0);
    rep(1, 5, 5, 32'h55);
    exc_ack = 1;
    @(negedge clk);
    chk("t3 ready on ack", report_ready, 1);
    tick();
    exc_ack = 0;
    rep(0, 0, 0, 0);
    discard_active = 1;
    @(negedge clk);
    chk("t3 valid", exc_valid, 0);
    chk("t3 count", pending_count, 0);
    chk("t3 dropped", table_we, 0);
    tick();
    tick();
    tick();
    discard_active = 0;
    rep(1, 6, 6, 32'h66);
    @(negedge clk);
    chk("t4 ready", report_ready, 1);
    tick();
    rep(1, 4, 3, 32'h44);
    @(negedge clk);
    chk("t4 no write", table_we, 0);
    chk("t4 count", pending_count, 0);
    tick();
    rep(0, 0, 0, 0);
    @(negedge clk);
    chk("t3 idle accept", exc_valid, 1);
    chk("t3 idle id", exc_id, 4);
    chk("t3 idle write", table_we, 1);
    exc_ack = 1;
    tick();
    exc_ack = 0;
    tick();
    tick();
    rep(1, 1, 1, 32'h1);
    tick();
    rep(1, 2, 2, 32'h2);
    tick();
    rep(1, 3, 3, 32'h3);
    clear = 1;
    tick();
    clear = 0;
    rep(0, 0, 0, 0);
    @(negedge clk);
    chk("t5 clear valid", exc_valid, 0);
    chk("t5 clear count", pending_count, 0);
    chk("t5 clear write", table_we, 0);
    rep(1, 2, 9, 32'h9);
    tick();
    rep(1, 5, 1, 32'h5);
    tick();
    rep(0, 0, 0, 0);
    @(negedge clk);
    chk("t5 refill count", pending_count, 2);
    chk("t5 refill head", exc_id, 2);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("t5 rst valid", exc_valid, 0);
    chk("t5 rst count", pending_count, 0);
    chk("t5 rst write", table_we, 0);
    for (int i = 0; i < 40; i++) begin
      rep(i % 3 != 2, 3'(i), 5'(i * 3), 32'(i) * 32'h01010101);
      exc_ack = i % 5 == 4;
      discard_active = i % 7 < 2;
      clear = i == 23;
      tick();
    end
    rep(0, 0, 0, 0);
    exc_ack = 0;
    discard_active = 0;
    clear = 0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
